fpu_issue_sched: RTL and testbench

FPU_ISSUE_SCHED -- requirements
Module: fpu_issue_sched

---
 rtl/fpu_sched_pkg.sv | 31 +++
 rtl/fpu_tag_pipe.sv | 48 ++++
 rtl/fpu_issue_sched.sv | 145 ++++++++++++++
 tb/tb_fpu_issue_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared types and default constants for the FPU issue scheduler.
//
// Contents:
//   DEF_LATENCY / DEF_OP_W / DEF_DATA_W : default parameter values
//   REQ_ID_W     : storage width of a requester ID (up to 16 requesters)
//   req_id_t     : requester ID as carried through the tag pipe
//   tag_entry_t  : one ID-pipe entry {valid, id}
//   rr_index()   : candidate index for round-robin search
package fpu_sched_pkg;

    localparam int DEF_LATENCY = 4;
    localparam int DEF_OP_W    = 3;
    localparam int DEF_DATA_W  = 32;

    // IDs are stored at a fixed width so the entry struct does not depend
    // on N_REQ; the top only uses the low clog2(N_REQ) bits.
    localparam int REQ_ID_W = 4;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_entry_t;

    // k-th candidate when searching upward from the requester after 'last'.
    function automatic int rr_index(input int last, input int k, input int n);
        return (last + 1 + k) % n;
    endfunction

endpackage

// File: rtl/fpu_tag_pipe.sv
// Enable-gated shift pipe carrying {valid, id} tags alongside the FPU pipeline.
//
// Parameters: WIDTH (entry width), STAGES (depth, >= 1)
// Ports:
//   clk_i  : clock
//   clear  : synchronous clear of every stage (wins over enable)
//   enable : advance all stages by one; when low all stages hold
//   din    : entry shifted into stage 0
//   dout   : last stage
module fpu_tag_pipe #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;
            logic [WIDTH-1:0] stage_next;

            if (gi == 0) begin : g_first
                assign stage_next = din;
            end else begin : g_rest
                assign stage_next = stage_q[gi-1];
            end

            always_ff @(posedge clk_i) begin
                if (clear) begin
                    stage_reg <= '0;
                end else if (enable) begin
                    stage_reg <= stage_next;
                end
            end

            assign stage_q[gi] = stage_reg;
        end
    endgenerate

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/fpu_issue_sched.sv
// Round-robin issue scheduler for a shared, fully pipelined FPU.
// Grants at most one requester per enabled cycle, tracks the owner of each
// operation in a tag pipe matching the FPU depth, and returns the FPU result
// tagged with its owner. A stalled response freezes FPU and tag pipe together.
//
// Optional feature: define FPU_SCHED_FLUSH_EN to add flush_i, which drops all
// in-flight operations (round-robin pointer kept).
//
// Ports:
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   req_valid_i / req_ready_o       : per-requester handshake (ready one-hot or 0)
//   req_op_i / req_a_i / req_b_i    : per-requester opcode and operands
//   fpu_en_o                        : pipeline advance enable
//   fpu_valid_o, fpu_op_o, fpu_a_o, fpu_b_o : granted operation to the FPU
//   fpu_res_i                       : FPU last-stage result
//   rsp_valid_o, rsp_id_o, rsp_data_o, rsp_ready_i : response channel
//   inflight_o                      : accepted, not yet retired operations
//   flush_i (FPU_SCHED_FLUSH_EN)    : drop all in-flight operations
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int LATENCY = DEF_LATENCY,
    parameter int OP_W    = DEF_OP_W,
    parameter int DATA_W  = DEF_DATA_W,
    localparam int ID_W   = $clog2(N_REQ),
    localparam int IF_W   = $clog2(LATENCY + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef FPU_SCHED_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0][OP_W-1:0]    req_op_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_a_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_b_i,
    output logic                          fpu_en_o,
    output logic                          fpu_valid_o,
    output logic [OP_W-1:0]               fpu_op_o,
    output logic [DATA_W-1:0]             fpu_a_o,
    output logic [DATA_W-1:0]             fpu_b_o,
    input  logic [DATA_W-1:0]             fpu_res_i,
    output logic                          rsp_valid_o,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [DATA_W-1:0]             rsp_data_o,
    input  logic                          rsp_ready_i,
    output logic [IF_W-1:0]               inflight_o
);

    logic [ID_W-1:0] rr_ptr_reg;     // last granted requester
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_id;
    logic            grant_found;
    logic            grant_allow;
    logic            accept;
    logic            handshake;
    logic            pipe_clr;
    logic [IF_W-1:0] inflight_reg;
    tag_entry_t      tag_in;
    tag_entry_t      tag_out;
    logic            unused_id_bits;

    // Response side: a pending response that is not taken freezes everything.
    assign rsp_valid_o = tag_out.valid;
    assign rsp_id_o    = tag_out.id[ID_W-1:0];
    assign rsp_data_o  = fpu_res_i;
    assign fpu_en_o    = !rsp_valid_o || rsp_ready_i;
    assign handshake   = rsp_valid_o && rsp_ready_i;

`ifdef FPU_SCHED_FLUSH_EN
    assign pipe_clr    = rst_i || flush_i;
    assign grant_allow = fpu_en_o && !rst_i && !flush_i;
`else
    assign pipe_clr    = rst_i;
    assign grant_allow = fpu_en_o && !rst_i;
`endif

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'(rr_index(int'(rr_ptr_reg), k, N_REQ));
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign accept = grant_allow && grant_found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign fpu_valid_o = accept;
    assign fpu_op_o    = req_op_i[grant_id];
    assign fpu_a_o     = req_a_i[grant_id];
    assign fpu_b_o     = req_b_i[grant_id];

    assign tag_in = '{valid: accept, id: req_id_t'(grant_id)};

    fpu_tag_pipe #(
        .WIDTH  ($bits(tag_entry_t)),
        .STAGES (LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .clear  (pipe_clr),
        .enable (fpu_en_o),
        .din    (tag_in),
        .dout   (tag_out)
    );

    // Upper ID storage bits are always zero for this N_REQ.
    assign unused_id_bits = ^tag_out.id;

    // Reset points at the highest index so requester 0 wins next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            rr_ptr_reg <= grant_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pipe_clr) begin
            inflight_reg <= '0;
        end else if (accept && !handshake) begin
            inflight_reg <= inflight_reg + IF_W'(1);
        end else if (!accept && handshake) begin
            inflight_reg <= inflight_reg - IF_W'(1);
        end
    end

    assign inflight_o = inflight_reg;

endmodule

// File: tb/tb_fpu_issue_sched.sv
module tb_fpu_issue_sched;

    localparam int N_REQ   = 2;
    localparam int LATENCY = 4;
    localparam int OP_W    = 3;
    localparam int DATA_W  = 32;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         flush = 1'b0;
    logic [N_REQ-1:0]             req_valid = '0;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0][OP_W-1:0]   req_op = '0;
    logic [N_REQ-1:0][DATA_W-1:0] req_a = '0;
    logic [N_REQ-1:0][DATA_W-1:0] req_b = '0;
    logic                         fpu_en;
    logic                         fpu_valid;
    logic [OP_W-1:0]              fpu_op;
    logic [DATA_W-1:0]            fpu_a;
    logic [DATA_W-1:0]            fpu_b;
    logic [DATA_W-1:0]            fpu_res = '0;
    logic                         rsp_valid;
    logic [0:0]                   rsp_id;
    logic [DATA_W-1:0]            rsp_data;
    logic                         rsp_ready = 1'b1;
    logic [2:0]                   inflight;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_issue_sched #(
        .N_REQ   (N_REQ),
        .LATENCY (LATENCY),
        .OP_W    (OP_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef FPU_SCHED_FLUSH_EN
        .flush_i     (flush),
`endif
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .fpu_en_o    (fpu_en),
        .fpu_valid_o (fpu_valid),
        .fpu_op_o    (fpu_op),
        .fpu_a_o     (fpu_a),
        .fpu_b_o     (fpu_b),
        .fpu_res_i   (fpu_res),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_data_o  (rsp_data),
        .rsp_ready_i (rsp_ready),
        .inflight_o  (inflight)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Each accepted op remembers how many enabled edges had happened when it
    // was accepted; it is presented once LATENCY-1 further enabled edges pass.
    typedef struct {
        int id;
        int tag;
    } op_t;

    op_t q[$];
    int  en_cnt = 0;
    int  last_g = N_REQ - 1;
    bit  started = 0;

    always @(negedge clk) begin
        bit              m_rsp_v;
        bit              m_en;
        bit              m_allow;
        bit              m_found;
        int              m_g;
        int              idx;
        logic [N_REQ-1:0] m_ready;
        m_found = 0;
        m_g     = 0;
        m_ready = '0;
        m_rsp_v = (q.size() > 0) && ((en_cnt - q[0].tag) == LATENCY - 1);
        m_en    = !m_rsp_v || rsp_ready;
        m_allow = m_en && !rst && !flush;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (last_g + k) % N_REQ;
            if (!m_found && req_valid[idx]) begin
                m_found = 1;
                m_g     = idx;
            end
        end
        if (m_allow && m_found) m_ready[m_g] = 1'b1;

        if (started) begin
            chk("model.fpu_en", 64'(fpu_en), 64'(m_en));
            chk("model.req_ready", 64'(req_ready), 64'(m_ready));
            chk("model.fpu_valid", 64'(fpu_valid), 64'(m_allow && m_found));
            chk("model.rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
            chk("model.inflight", 64'(inflight), 64'(q.size()));
            if (m_allow && m_found) begin
                chk("model.fpu_op", 64'(fpu_op), 64'(req_op[m_g]));
                chk("model.fpu_a", 64'(fpu_a), 64'(req_a[m_g]));
                chk("model.fpu_b", 64'(fpu_b), 64'(req_b[m_g]));
                $display("issue  req%0d op=%0h a=%h b=%h", m_g, req_op[m_g], req_a[m_g], req_b[m_g]);
            end
            if (m_rsp_v) begin
                chk("model.rsp_id", 64'(rsp_id), 64'(q[0].id));
                chk("model.rsp_data", 64'(rsp_data), 64'(fpu_res));
                if (rsp_ready) $display("resp   id=%0d data=%h", q[0].id, fpu_res);
            end
        end

        if (rst) begin
            q.delete();
            last_g  = N_REQ - 1;
            started = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (m_rsp_v && rsp_ready) void'(q.pop_front());
            if (m_en) en_cnt++;
            if (m_allow && m_found) begin
                q.push_back('{id: m_g, tag: en_cnt});
                last_g = m_g;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [N_REQ-1:0] v, input logic rdy, input logic fl, input logic r);
        req_valid = v;
        rsp_ready = rdy;
        flush     = fl;
        rst       = r;
        for (int i = 0; i < N_REQ; i++) begin
            req_op[i] = OP_W'($urandom);
            req_a[i]  = $urandom;
            req_b[i]  = $urandom;
        end
        fpu_res = $urandom;
    endtask

    task automatic do_reset();
        set_in(2'b00, 1'b1, 1'b0, 1'b1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) step();

        // Single request: grant at 0, response at 4, inflight 1 over 1..4.
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            set_in((c == 0) ? 2'b01 : 2'b00, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (c == 0) chk("s1.ready_c0", 64'(req_ready), 64'h1);
            if (c >= 1 && c <= 4) chk("s1.inflight", 64'(inflight), 64'd1);
            if (c >= 1 && c <= 3) chk("s1.rsp_idle", 64'(rsp_valid), 64'd0);
            if (c == 4) begin
                chk("s1.rsp_valid_c4", 64'(rsp_valid), 64'd1);
                chk("s1.rsp_id_c4", 64'(rsp_id), 64'd0);
            end
            if (c == 5) chk("s1.inflight_c5", 64'(inflight), 64'd0);
            step();
        end

        // Contention: grants 0,1,0,1..., responses alternate from cycle 4.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            set_in((c < 8) ? 2'b11 : 2'b00, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            if (c < 8) chk("s2.ready", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            if (c >= 4 && c < 12) begin
                chk("s2.rsp_valid", 64'(rsp_valid), 64'd1);
                chk("s2.rsp_id", 64'(rsp_id), 64'((c - 4) % 2));
            end
            if (c == 12) chk("s2.rsp_done", 64'(rsp_valid), 64'd0);
            step();
        end

        // Stall: consumer not ready in cycles 4..6.
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            set_in((c < 10) ? 2'b01 : 2'b00, !(c >= 4 && c <= 6), 1'b0, 1'b0);
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                chk("s3.fpu_en", 64'(fpu_en), 64'd0);
                chk("s3.ready", 64'(req_ready), 64'd0);
                chk("s3.inflight", 64'(inflight), 64'd4);
                chk("s3.rsp_valid", 64'(rsp_valid), 64'd1);
                chk("s3.rsp_id", 64'(rsp_id), 64'd0);
            end
            if (c == 7) chk("s3.ready_c7", 64'(req_ready), 64'h1);
            if (c == 8) chk("s3.inflight_c8", 64'(inflight), 64'd4);
            step();
        end

        // Reset with three ops in flight: nothing comes back, req0 wins next.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            set_in((c <= 4) ? 2'b11 : 2'b00, 1'b1, 1'b0, (c == 3));
            @(negedge clk);
            if (c == 3) begin
                chk("s4.ready_in_rst", 64'(req_ready), 64'd0);
                chk("s4.inflight_pre", 64'(inflight), 64'd3);
            end
            if (c == 4) begin
                chk("s4.inflight_post", 64'(inflight), 64'd0);
                chk("s4.ready_post", 64'(req_ready), 64'h1);
            end
            if (c >= 4 && c <= 7) chk("s4.no_rsp", 64'(rsp_valid), 64'd0);
            if (c == 8) begin
                chk("s4.rsp_new", 64'(rsp_valid), 64'd1);
                chk("s4.rsp_new_id", 64'(rsp_id), 64'd0);
            end
            step();
        end

`ifdef FPU_SCHED_FLUSH_EN
        // Flush with two ops in flight; pointer kept so req1 wins at cycle 3.
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            set_in((c <= 1) ? 2'b01 : ((c <= 3) ? 2'b11 : 2'b00), 1'b1, (c == 2), 1'b0);
            @(negedge clk);
            if (c == 2) begin
                chk("s5.ready_flush", 64'(req_ready), 64'd0);
                chk("s5.inflight_pre", 64'(inflight), 64'd2);
            end
            if (c == 3) begin
                chk("s5.inflight_post", 64'(inflight), 64'd0);
                chk("s5.ready_resume", 64'(req_ready), 64'h2);
            end
            if (c >= 3 && c <= 6) chk("s5.no_rsp", 64'(rsp_valid), 64'd0);
            if (c == 7) chk("s5.rsp_id", 64'(rsp_id), 64'd1);
            if (c == 8) chk("s5.inflight_end", 64'(inflight), 64'd0);
            step();
        end
`endif

        // Mixed traffic checked by the model only.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            logic fl;
            fl = 1'b0;
`ifdef FPU_SCHED_FLUSH_EN
            fl = ($urandom_range(0, 40) == 0);
`endif
            set_in(N_REQ'($urandom), ($urandom_range(0, 3) != 0), fl, ($urandom_range(0, 80) == 0));
            step();
        end
        for (int c = 0; c < 12; c++) begin
            set_in(2'b00, 1'b1, 1'b0, 1'b0);
            step();
        end
        @(negedge clk);
        chk("end.inflight", 64'(inflight), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
